// File: rtl/riscv_pkg.sv
// Shared RV32 memory-stage encodings: load/store size/sign fields, access sizes,
// memory-stage FSM states and the alignment rule used by the memory unit.
package riscv_pkg;

  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;

  typedef enum logic {
    ME_IDLE = 1'b0,
    ME_WAIT = 1'b1
  } me_state_e;

  // Bytes are never misaligned; halfwords need addr[0]=0, words addr[1:0]=0.
  function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] addr);
    logic mis;
    mis = 1'b0;
    if (size == SZ_HALF) mis = addr[0];
    else if (size == SZ_WORD) mis = |addr;
    return mis;
  endfunction

endpackage

// File: rtl/load_align.sv
// Load lane extraction: selects the byte/halfword addressed within the
// returned word and sign- or zero-extends it according to funct3.
module load_align
  import riscv_pkg::*;
(
  input  logic [1:0]  addr_i,
  input  logic [2:0]  funct3_i,
  input  logic [31:0] rdata_i,
  output logic [31:0] result_o
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  always_comb begin
    case (addr_i)
      2'd0:    byte_sel = rdata_i[7:0];
      2'd1:    byte_sel = rdata_i[15:8];
      2'd2:    byte_sel = rdata_i[23:16];
      default: byte_sel = rdata_i[31:24];
    endcase
    half_sel = addr_i[1] ? rdata_i[31:16] : rdata_i[15:0];

    case (funct3_i)
      F3_LB:   result_o = {{24{byte_sel[7]}}, byte_sel};
      F3_LH:   result_o = {{16{half_sel[15]}}, half_sel};
      F3_LBU:  result_o = {24'h0, byte_sel};
      F3_LHU:  result_o = {16'h0, half_sel};
      F3_LW:   result_o = rdata_i;
      default: result_o = rdata_i;
    endcase
  end

endmodule

// File: rtl/memory_unit.sv
// Pipeline memory stage: issues data-memory requests, stalls the pipe while
// the memory is busy, formats store/load data and registers the ME/WB stage.
module memory_unit
  import riscv_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        EX_ME_valid,
  input  logic [31:0] EX_ME_ALU_result,
  input  logic [31:0] EX_ME_rs2_data,
  input  logic [4:0]  EX_ME_rd,
  input  logic        EX_ME_RegWrite,
  input  logic        EX_ME_MemtoReg,
  input  logic        EX_ME_MemRead,
  input  logic        EX_ME_MemWrite,
  input  logic [2:0]  EX_ME_funct3,
  input  logic        dmem_ready,
  input  logic [31:0] dmem_rdata,
  output logic        dmem_req,
  output logic        dmem_we,
  output logic [31:0] dmem_addr,
  output logic [31:0] dmem_wdata,
  output logic [3:0]  dmem_wstrb,
  output logic        ME_stall,
  output logic        ME_misaligned,
  output logic [31:0] ME_WB_data,
  output logic [31:0] ME_WB_ALU_result,
  output logic [4:0]  ME_WB_rd,
  output logic        ME_WB_RegWrite,
  output logic        ME_WB_MemtoReg,
  output logic [15:0] ME_stall_count
);

  me_state_e   state_q, state_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic [3:0]  wstrb_q, wstrb_d;
  logic        we_q, we_d;
  logic [2:0]  funct3_q, funct3_d;
  logic [4:0]  rd_q, rd_d;
  logic        regwrite_q, regwrite_d;
  logic        memtoreg_q, memtoreg_d;

  logic [31:0] wb_data_q, wb_data_d;
  logic [31:0] wb_alu_q, wb_alu_d;
  logic [4:0]  wb_rd_q, wb_rd_d;
  logic        wb_regwrite_q, wb_regwrite_d;
  logic        wb_memtoreg_q, wb_memtoreg_d;
  logic [15:0] stall_cnt_q, stall_cnt_d;

  logic        in_wait, mem_op, misaligned_op, aligned_op;
  logic [31:0] st_wdata;
  logic [3:0]  st_wstrb;
  logic [31:0] act_addr, act_wdata;
  logic [3:0]  act_wstrb;
  logic        act_we, act_load, act_regwrite, act_memtoreg;
  logic [2:0]  act_funct3;
  logic [4:0]  act_rd;
  logic [31:0] load_result;
  logic        wb_update;

  assign in_wait       = (state_q == ME_WAIT);
  assign mem_op        = EX_ME_valid & (EX_ME_MemRead | EX_ME_MemWrite);
  assign misaligned_op = mem_op & is_misaligned(EX_ME_funct3[1:0], EX_ME_ALU_result[1:0]);
  assign aligned_op    = mem_op & ~misaligned_op;

  // Store data is replicated across lanes so the strobe alone picks the bytes.
  always_comb begin
    case (EX_ME_funct3[1:0])
      SZ_BYTE: begin
        st_wdata = {4{EX_ME_rs2_data[7:0]}};
        st_wstrb = 4'b0001 << EX_ME_ALU_result[1:0];
      end
      SZ_HALF: begin
        st_wdata = {2{EX_ME_rs2_data[15:0]}};
        st_wstrb = EX_ME_ALU_result[1] ? 4'b1100 : 4'b0011;
      end
      default: begin
        st_wdata = EX_ME_rs2_data;
        st_wstrb = 4'b1111;
      end
    endcase
    if (!EX_ME_MemWrite) st_wstrb = 4'b0000;
  end

  // In WAIT the upstream inputs are don't-care, so everything comes from holding regs.
  assign act_addr     = in_wait ? addr_q     : EX_ME_ALU_result;
  assign act_we       = in_wait ? we_q       : EX_ME_MemWrite;
  assign act_wdata    = in_wait ? wdata_q    : st_wdata;
  assign act_wstrb    = in_wait ? wstrb_q    : st_wstrb;
  assign act_funct3   = in_wait ? funct3_q   : EX_ME_funct3;
  assign act_rd       = in_wait ? rd_q       : EX_ME_rd;
  assign act_regwrite = in_wait ? regwrite_q : EX_ME_RegWrite;
  assign act_memtoreg = in_wait ? memtoreg_q : EX_ME_MemtoReg;
  assign act_load     = in_wait ? ~we_q      : (EX_ME_valid & EX_ME_MemRead);

  assign dmem_req      = reset & (in_wait | aligned_op);
  assign dmem_we       = act_we;
  assign dmem_addr     = {act_addr[31:2], 2'b00};
  assign dmem_wdata    = act_wdata;
  assign dmem_wstrb    = act_wstrb;
  assign ME_stall      = dmem_req & ~dmem_ready;
  assign ME_misaligned = reset & ~in_wait & misaligned_op;

  load_align u_load_align (
    .addr_i   (act_addr[1:0]),
    .funct3_i (act_funct3),
    .rdata_i  (dmem_rdata),
    .result_o (load_result)
  );

  always_comb begin
    state_d    = state_q;
    addr_d     = addr_q;
    we_d       = we_q;
    wdata_d    = wdata_q;
    wstrb_d    = wstrb_q;
    funct3_d   = funct3_q;
    rd_d       = rd_q;
    regwrite_d = regwrite_q;
    memtoreg_d = memtoreg_q;
    case (state_q)
      ME_IDLE: begin
        if (aligned_op && !dmem_ready) begin
          state_d    = ME_WAIT;
          addr_d     = EX_ME_ALU_result;
          we_d       = EX_ME_MemWrite;
          wdata_d    = st_wdata;
          wstrb_d    = st_wstrb;
          funct3_d   = EX_ME_funct3;
          rd_d       = EX_ME_rd;
          regwrite_d = EX_ME_RegWrite;
          memtoreg_d = EX_ME_MemtoReg;
        end
      end
      ME_WAIT: begin
        if (dmem_ready) state_d = ME_IDLE;
      end
      default: state_d = ME_IDLE;
    endcase
  end

  // Stalls and dropped/absent instructions insert a bubble; other fields hold.
  assign wb_update = ~ME_stall & (in_wait | (EX_ME_valid & ~misaligned_op));

  always_comb begin
    wb_data_d     = wb_data_q;
    wb_alu_d      = wb_alu_q;
    wb_rd_d       = wb_rd_q;
    wb_regwrite_d = 1'b0;
    wb_memtoreg_d = 1'b0;
    if (wb_update) begin
      wb_alu_d      = act_addr;
      wb_rd_d       = act_rd;
      wb_regwrite_d = act_regwrite;
      wb_memtoreg_d = act_memtoreg;
      if (act_load) wb_data_d = load_result;
    end
    stall_cnt_d = stall_cnt_q;
    if (ME_stall && stall_cnt_q != 16'hFFFF) stall_cnt_d = stall_cnt_q + 16'd1;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q       <= ME_IDLE;
      addr_q        <= '0;
      we_q          <= 1'b0;
      wdata_q       <= '0;
      wstrb_q       <= '0;
      funct3_q      <= '0;
      rd_q          <= '0;
      regwrite_q    <= 1'b0;
      memtoreg_q    <= 1'b0;
      wb_data_q     <= '0;
      wb_alu_q      <= '0;
      wb_rd_q       <= '0;
      wb_regwrite_q <= 1'b0;
      wb_memtoreg_q <= 1'b0;
      stall_cnt_q   <= '0;
    end else begin
      state_q       <= state_d;
      addr_q        <= addr_d;
      we_q          <= we_d;
      wdata_q       <= wdata_d;
      wstrb_q       <= wstrb_d;
      funct3_q      <= funct3_d;
      rd_q          <= rd_d;
      regwrite_q    <= regwrite_d;
      memtoreg_q    <= memtoreg_d;
      wb_data_q     <= wb_data_d;
      wb_alu_q      <= wb_alu_d;
      wb_rd_q       <= wb_rd_d;
      wb_regwrite_q <= wb_regwrite_d;
      wb_memtoreg_q <= wb_memtoreg_d;
      stall_cnt_q   <= stall_cnt_d;
    end
  end

  assign ME_WB_data       = wb_data_q;
  assign ME_WB_ALU_result = wb_alu_q;
  assign ME_WB_rd         = wb_rd_q;
  assign ME_WB_RegWrite   = wb_regwrite_q;
  assign ME_WB_MemtoReg   = wb_memtoreg_q;
  assign ME_stall_count   = stall_cnt_q;

endmodule

// File: tb/tb_memory_unit.sv
// Bench for memory_unit: directed scenarios plus randomized traffic checked
// against a transaction-level model of the memory stage.
module tb_memory_unit;

  logic        clk = 1'b0;
  logic        reset;
  logic        EX_ME_valid;
  logic [31:0] EX_ME_ALU_result;
  logic [31:0] EX_ME_rs2_data;
  logic [4:0]  EX_ME_rd;
  logic        EX_ME_RegWrite;
  logic        EX_ME_MemtoReg;
  logic        EX_ME_MemRead;
  logic        EX_ME_MemWrite;
  logic [2:0]  EX_ME_funct3;
  logic        dmem_ready;
  logic [31:0] dmem_rdata;
  logic        dmem_req;
  logic        dmem_we;
  logic [31:0] dmem_addr;
  logic [31:0] dmem_wdata;
  logic [3:0]  dmem_wstrb;
  logic        ME_stall;
  logic        ME_misaligned;
  logic [31:0] ME_WB_data;
  logic [31:0] ME_WB_ALU_result;
  logic [4:0]  ME_WB_rd;
  logic        ME_WB_RegWrite;
  logic        ME_WB_MemtoReg;
  logic [15:0] ME_stall_count;

  memory_unit dut (
    .clk              (clk),
    .reset            (reset),
    .EX_ME_valid      (EX_ME_valid),
    .EX_ME_ALU_result (EX_ME_ALU_result),
    .EX_ME_rs2_data   (EX_ME_rs2_data),
    .EX_ME_rd         (EX_ME_rd),
    .EX_ME_RegWrite   (EX_ME_RegWrite),
    .EX_ME_MemtoReg   (EX_ME_MemtoReg),
    .EX_ME_MemRead    (EX_ME_MemRead),
    .EX_ME_MemWrite   (EX_ME_MemWrite),
    .EX_ME_funct3     (EX_ME_funct3),
    .dmem_ready       (dmem_ready),
    .dmem_rdata       (dmem_rdata),
    .dmem_req         (dmem_req),
    .dmem_we          (dmem_we),
    .dmem_addr        (dmem_addr),
    .dmem_wdata       (dmem_wdata),
    .dmem_wstrb       (dmem_wstrb),
    .ME_stall         (ME_stall),
    .ME_misaligned    (ME_misaligned),
    .ME_WB_data       (ME_WB_data),
    .ME_WB_ALU_result (ME_WB_ALU_result),
    .ME_WB_rd         (ME_WB_rd),
    .ME_WB_RegWrite   (ME_WB_RegWrite),
    .ME_WB_MemtoReg   (ME_WB_MemtoReg),
    .ME_stall_count   (ME_stall_count)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  // Reference model: an outstanding request record plus the expected ME/WB contents.
  logic        m_pend;
  logic [31:0] p_addr, p_rs2;
  logic [2:0]  p_f3;
  logic [4:0]  p_rd;
  logic        p_rw, p_m2r, p_mr, p_mw;
  logic [31:0] m_wb_data, m_wb_alu;
  logic [4:0]  m_wb_rd;
  logic        m_wb_rw, m_wb_m2r;
  int          m_cnt;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic f_mis(input logic [2:0] f3, input logic [31:0] a);
    if (f3 == 3'd1 || f3 == 3'd5) return (a % 2) != 0;
    if (f3 == 3'd2) return (a % 4) != 0;
    return 1'b0;
  endfunction

  function automatic logic [31:0] f_wstrb(input logic [2:0] f3, input logic [31:0] a, input logic wr);
    if (!wr) return 32'd0;
    if (f3 == 3'd0) return 32'd1 << (a % 4);
    if (f3 == 3'd1) return ((a % 4) >= 2) ? 32'd12 : 32'd3;
    return 32'd15;
  endfunction

  function automatic logic [31:0] f_wdata(input logic [2:0] f3, input logic [31:0] d);
    if (f3 == 3'd0) return (d & 32'hFF) * 32'h0101_0101;
    if (f3 == 3'd1) return (d & 32'hFFFF) * 32'h0001_0001;
    return d;
  endfunction

  function automatic logic [31:0] f_load(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] r);
    logic [31:0] v;
    if (f3 == 3'd0 || f3 == 3'd4) begin
      v = (r >> (8 * (a % 4))) & 32'hFF;
      if (f3 == 3'd0 && v >= 32'd128) v = v + 32'hFFFF_FF00;
      return v;
    end
    if (f3 == 3'd1 || f3 == 3'd5) begin
      v = (((a % 4) >= 2) ? (r >> 16) : r) & 32'hFFFF;
      if (f3 == 3'd1 && v >= 32'd32768) v = v + 32'hFFFF_0000;
      return v;
    end
    return r;
  endfunction

  task automatic model_reset();
    m_pend = 1'b0;
    m_wb_data = '0; m_wb_alu = '0; m_wb_rd = '0; m_wb_rw = 1'b0; m_wb_m2r = 1'b0;
    m_cnt = 0;
  endtask

  task automatic drive(input logic v, input logic [31:0] a, input logic [31:0] d, input logic [4:0] rd,
                       input logic rw, input logic m2r, input logic mr, input logic mw, input logic [2:0] f3);
    EX_ME_valid = v; EX_ME_ALU_result = a; EX_ME_rs2_data = d; EX_ME_rd = rd;
    EX_ME_RegWrite = rw; EX_ME_MemtoReg = m2r; EX_ME_MemRead = mr; EX_ME_MemWrite = mw;
    EX_ME_funct3 = f3;
  endtask

  // Entered just after a falling edge with EX inputs driven; returns at the next falling edge.
  task automatic step(input logic rdy, input logic [31:0] rdata);
    logic        c_valid, c_rw, c_m2r, c_mr, c_mw, memop, mis, req, stall;
    logic [31:0] c_addr, c_rs2;
    logic [2:0]  c_f3;
    logic [4:0]  c_rd;
    dmem_ready = rdy;
    dmem_rdata = rdata;
    #1;
    if (m_pend) begin
      c_valid = 1'b1; c_addr = p_addr; c_rs2 = p_rs2; c_f3 = p_f3; c_rd = p_rd;
      c_rw = p_rw; c_m2r = p_m2r; c_mr = p_mr; c_mw = p_mw;
    end else begin
      c_valid = EX_ME_valid; c_addr = EX_ME_ALU_result; c_rs2 = EX_ME_rs2_data; c_f3 = EX_ME_funct3;
      c_rd = EX_ME_rd; c_rw = EX_ME_RegWrite; c_m2r = EX_ME_MemtoReg; c_mr = EX_ME_MemRead; c_mw = EX_ME_MemWrite;
    end
    memop = c_valid && (c_mr || c_mw);
    mis   = !m_pend && memop && f_mis(c_f3, c_addr);
    req   = m_pend || (memop && !mis);
    stall = req && !rdy;
    check("dmem_req", 32'(dmem_req), 32'(req));
    check("ME_stall", 32'(ME_stall), 32'(stall));
    check("ME_misaligned", 32'(ME_misaligned), 32'(mis));
    if (req) begin
      check("dmem_addr", dmem_addr, c_addr & 32'hFFFF_FFFC);
      check("dmem_we", 32'(dmem_we), 32'(c_mw));
      check("dmem_wstrb", 32'(dmem_wstrb), f_wstrb(c_f3, c_addr, c_mw));
      if (c_mw) check("dmem_wdata", dmem_wdata, f_wdata(c_f3, c_rs2));
    end
    @(posedge clk);
    if (stall) begin
      m_wb_rw = 1'b0; m_wb_m2r = 1'b0;
      if (m_cnt < 65535) m_cnt++;
      m_pend = 1'b1;
      p_addr = c_addr; p_rs2 = c_rs2; p_f3 = c_f3; p_rd = c_rd;
      p_rw = c_rw; p_m2r = c_m2r; p_mr = c_mr; p_mw = c_mw;
    end else if (req || (c_valid && !mis)) begin
      m_wb_alu = c_addr; m_wb_rd = c_rd; m_wb_rw = c_rw; m_wb_m2r = c_m2r;
      if (c_mr) m_wb_data = f_load(c_f3, c_addr, rdata);
      m_pend = 1'b0;
    end else begin
      m_wb_rw = 1'b0; m_wb_m2r = 1'b0;
    end
    #1;
    check("ME_WB_RegWrite", 32'(ME_WB_RegWrite), 32'(m_wb_rw));
    check("ME_WB_MemtoReg", 32'(ME_WB_MemtoReg), 32'(m_wb_m2r));
    check("ME_WB_rd", 32'(ME_WB_rd), 32'(m_wb_rd));
    check("ME_WB_ALU_result", ME_WB_ALU_result, m_wb_alu);
    check("ME_WB_data", ME_WB_data, m_wb_data);
    check("ME_stall_count", 32'(ME_stall_count), 32'(m_cnt));
    @(negedge clk);
  endtask

  initial begin
    logic [2:0] ld_tab [5];
    int         kind;
    logic [2:0] f3;
    ld_tab = '{3'd0, 3'd1, 3'd2, 3'd4, 3'd5};

    // Reset state
    reset = 1'b0;
    dmem_ready = 1'b0;
    dmem_rdata = '0;
    drive(1'b0, '0, '0, '0, 1'b0, 1'b0, 1'b0, 1'b0, 3'd0);
    model_reset();
    #2;
    check("rst_dmem_req", 32'(dmem_req), 32'd0);
    check("rst_stall", 32'(ME_stall), 32'd0);
    check("rst_wb_regwrite", 32'(ME_WB_RegWrite), 32'd0);
    check("rst_stall_count", 32'(ME_stall_count), 32'd0);
    repeat (2) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);

    // LW zero-wait
    drive(1'b1, 32'h100, 32'h0, 5'd5, 1'b1, 1'b1, 1'b1, 1'b0, 3'd2);
    step(1'b1, 32'hDEAD_BEEF);
    check("lw_data", ME_WB_data, 32'hDEAD_BEEF);
    check("lw_regwrite", 32'(ME_WB_RegWrite), 32'd1);

    // LB with three wait cycles
    drive(1'b1, 32'h103, 32'h0, 5'd7, 1'b1, 1'b1, 1'b1, 1'b0, 3'd0);
    for (int i = 0; i < 3; i++) step(1'b0, 32'h0);
    step(1'b1, 32'h80FF_00AA);
    check("lb_data", ME_WB_data, 32'hFFFF_FF80);
    check("lb_stall_count", 32'(ME_stall_count), 32'd3);

    // SH store formatting
    drive(1'b1, 32'h202, 32'h0000_1234, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1, 3'd1);
    dmem_ready = 1'b1;
    #1;
    check("sh_addr", dmem_addr, 32'h200);
    check("sh_wdata", dmem_wdata, 32'h1234_1234);
    check("sh_wstrb", 32'(dmem_wstrb), 32'hC);
    check("sh_we", 32'(dmem_we), 32'd1);
    step(1'b1, 32'h0);

    // Misaligned LW dropped
    drive(1'b1, 32'h101, 32'h0, 5'd9, 1'b1, 1'b1, 1'b1, 1'b0, 3'd2);
    dmem_ready = 1'b1;
    #1;
    check("mis_req", 32'(dmem_req), 32'd0);
    check("mis_pulse", 32'(ME_misaligned), 32'd1);
    step(1'b1, 32'h0);
    check("mis_regwrite", 32'(ME_WB_RegWrite), 32'd0);

    // Reset while waiting
    drive(1'b1, 32'h300, 32'h0, 5'd3, 1'b1, 1'b1, 1'b1, 1'b0, 3'd2);
    step(1'b0, 32'h0);
    dmem_ready = 1'b0;
    #1;
    check("wait_req", 32'(dmem_req), 32'd1);
    #1;
    reset = 1'b0;
    #1;
    check("rstw_req", 32'(dmem_req), 32'd0);
    check("rstw_stall", 32'(ME_stall), 32'd0);
    check("rstw_wb_alu", ME_WB_ALU_result, 32'd0);
    check("rstw_wb_data", ME_WB_data, 32'd0);
    check("rstw_wb_rd", 32'(ME_WB_rd), 32'd0);
    check("rstw_count", 32'(ME_stall_count), 32'd0);
    model_reset();
    @(negedge clk);
    reset = 1'b1;
    drive(1'b0, 32'h0, 32'h0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 3'd0);
    step(1'b0, 32'h0);
    drive(1'b1, 32'h44, 32'h0, 5'd11, 1'b1, 1'b1, 1'b1, 1'b0, 3'd2);
    step(1'b1, 32'h1357_9BDF);

    // Randomized traffic
    for (int i = 0; i < 500; i++) begin
      if (m_pend) begin
        drive(1'($urandom), $urandom, $urandom, 5'($urandom), 1'($urandom), 1'($urandom),
              1'($urandom), 1'($urandom), 3'($urandom));
      end else begin
        kind = $urandom_range(0, 2);
        if (kind == 1) begin
          f3 = ld_tab[$urandom_range(0, 4)];
          drive($urandom_range(0, 7) != 0, $urandom, $urandom, 5'($urandom), 1'b1, 1'b1, 1'b1, 1'b0, f3);
        end else if (kind == 2) begin
          f3 = 3'($urandom_range(0, 2));
          drive($urandom_range(0, 7) != 0, $urandom, $urandom, 5'($urandom), 1'b0, 1'b0, 1'b0, 1'b1, f3);
        end else begin
          drive($urandom_range(0, 7) != 0, $urandom, $urandom, 5'($urandom), 1'($urandom), 1'b0, 1'b0, 1'b0,
                3'($urandom));
        end
      end
      step($urandom_range(0, 2) != 0, $urandom);
    end

    // Long stall saturates the counter
    drive(1'b1, 32'h500, 32'h0, 5'd12, 1'b1, 1'b1, 1'b1, 1'b0, 3'd2);
    step(1'b0, 32'h0);
    repeat (69999) @(posedge clk);
    m_cnt = (m_cnt + 69999 > 65535) ? 65535 : m_cnt + 69999;
    #1;
    check("sat_count", 32'(ME_stall_count), 32'(m_cnt));
    check("sat_count_ffff", 32'(ME_stall_count), 32'hFFFF);
    @(negedge clk);
    step(1'b1, 32'h2468_ACE0);
    check("sat_hold", 32'(ME_stall_count), 32'hFFFF);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
